// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline steering block: FSM encodings, forward selects
// and the default hardwired-zero register.
package pipe_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned ZERO_REG_DFLT = 31;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding comparator and 3:1 operand mux for one ALU source; MEM beats WB,
// and the zero register is never a forwarding source.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned ZERO_REG = ZERO_REG_DFLT
) (
  input  logic [RADDR_W-1:0] src,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_regwrite,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               wb_regwrite,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [1:0]         sel,
  output logic [DATA_W-1:0]  opnd
);

  localparam logic [RADDR_W-1:0] ZR = RADDR_W'(ZERO_REG);

  always_comb begin
    if (mem_regwrite && (mem_rd == src) && (mem_rd != ZR)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd == src) && (wb_rd != ZR)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

  always_comb begin
    case (sel)
      FWD_MEM: opnd = mem_data;
      FWD_WB:  opnd = wb_data;
      default: opnd = rf_data;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline steering: operand forwarding, load-use stall, data-memory wait and
// taken-branch flush for the 5-stage pipeline, plus stall/flush counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned ZERO_REG = ZERO_REG_DFLT,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [RADDR_W-1:0] id_rm,
  input  logic [RADDR_W-1:0] id_rn,
  input  logic               id_rm_used,
  input  logic               id_rn_used,
  input  logic [RADDR_W-1:0] ex_rm,
  input  logic [RADDR_W-1:0] ex_rn,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_memread,
  input  logic [DATA_W-1:0]  ex_rdata_a,
  input  logic [DATA_W-1:0]  ex_rdata_b,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_regwrite,
  input  logic [DATA_W-1:0]  mem_alu,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               br_taken,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               wb_regwrite,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  ex_opnd_a,
  output logic [DATA_W-1:0]  ex_opnd_b,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               freeze,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [RADDR_W-1:0] ZR        = RADDR_W'(ZERO_REG);
  localparam logic [3:0]         WAIT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu, mw, flush_all, flush_inc;

  fwd_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src(ex_rm), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .rf_data(ex_rdata_a), .mem_data(mem_alu), .wb_data(wb_data),
    .sel(fwd_a), .opnd(ex_opnd_a)
  );

  fwd_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src(ex_rn), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .rf_data(ex_rdata_b), .mem_data(mem_alu), .wb_data(wb_data),
    .sel(fwd_b), .opnd(ex_opnd_b)
  );

  assign lu = ex_memread && (ex_rd != ZR) &&
              ((id_rm_used && (id_rm == ex_rd)) || (id_rn_used && (id_rn == ex_rd)));
  assign mw = (MEM_LAT > 1) && mem_req && !mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    flush_all   = 1'b0;
    freeze      = 1'b0;
    if (resetl) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      flush_all   = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (br_taken) begin
            state_d = FLUSH;
          end else if (mw) begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_INIT;
          end else if (lu) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          freeze  = 1'b1;
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          // Leaving on the cycle the count would reach zero bounds the wait to MEM_LAT-1.
          if (mem_ready || (wait_q <= 4'd1)) begin
            state_d = RUN;
            wait_d  = 4'd0;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        FLUSH: begin
          flush_all = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign ifid_flush  = flush_all;
  assign idex_flush  = flush_all;
  assign exmem_flush = flush_all;
  assign flush_inc   = !resetl && (state_q == RUN) && br_taken;

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, ~pc_we};
      flush_q <= flush_q + {{(CNT_W-1){1'b0}}, flush_inc};
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised successor to the 5-stage LEGv8 pipeline's separate forwarding and hazard units; one block owns all pipeline steering.
- Functions: operand forwarding, load-use stall, multi-cycle data-memory wait, and taken-branch flush.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers; drives their enables and flushes and the two forwarded ALU operands.

Parameters:
- DATA_W, 64, datapath width.
- RADDR_W, 5, register address width.
- ZERO_REG, 31, hardwired-zero register (XZR); never a forwarding or hazard source.
- MEM_LAT, 1, maximum data-memory latency in cycles (1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- resetl  in  1  reset; synchronous, active-high.
- id_rm, id_rn  in  RADDR_W  ID-stage source registers.
- id_rm_used, id_rn_used  in  1  source actually read by the ID instruction.
- ex_rm, ex_rn  in  RADDR_W  EX-stage source registers.
- ex_rd  in  RADDR_W  EX-stage destination register.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rdata_a, ex_rdata_b  in  DATA_W  register-file values latched in ID/EX.
- mem_rd  in  RADDR_W  MEM-stage destination register.
- mem_regwrite  in  1  MEM-stage instruction writes a register.
- mem_alu  in  DATA_W  EX/MEM ALU result.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- br_taken  in  1  branch resolved taken in MEM.
- wb_rd  in  RADDR_W  WB-stage destination register.
- wb_regwrite  in  1  WB-stage instruction writes a register.
- wb_data  in  DATA_W  write-back value.
- ex_opnd_a, ex_opnd_b  out  DATA_W  forwarded ALU operands.
- fwd_a, fwd_b  out  2  forward select: 00 regfile, 01 WB, 10 MEM.
- pc_we, ifid_we  out  1  write enables.
- idex_bubble  out  1  zero the ID/EX control fields.
- ifid_flush, idex_flush, exmem_flush  out  1  clear those stage registers.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Forwarding, combinational:
  - fwd_a = 10 if mem_regwrite && mem_rd==ex_rm && mem_rd!=ZERO_REG.
  - Otherwise fwd_a = 01 if wb_regwrite && wb_rd==ex_rm && wb_rd!=ZERO_REG.
  - Otherwise fwd_a = 00. fwd_b is the same rule using ex_rn.
  - MEM has priority over WB.
- Hazard terms:
  - lu = ex_memread && ex_rd!=ZERO_REG && ((id_rm_used && id_rm==ex_rd) || (id_rn_used && id_rn==ex_rd)).
  - mw = mem_req && !mem_ready && MEM_LAT>1.
- FSM states: RUN, MEM_WAIT, FLUSH. State register and counters update on the rising edge of CLK.
- RUN:
  - If br_taken: go to FLUSH.
  - Else if mw: go to MEM_WAIT and load wait_cnt=MEM_LAT-1.
  - Else if lu: stay in RUN with pc_we=0, ifid_we=0, idex_bubble=1 for this cycle only.
  - Otherwise all enables are 1 and flushes are 0.
- MEM_WAIT:
  - freeze=1, pc_we=0, ifid_we=0; wait_cnt decrements each cycle.
  - Exit to RUN when mem_ready=1 or wait_cnt==0. A timeout is treated as completion.
  - br_taken is ignored while in this state. A branch held in MEM is re-evaluated in the first RUN cycle after the wait.
- FLUSH, one cycle:
  - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_we=1 so the branch target loads.
  - Then return to RUN.
  - br_taken has priority over lu and mw when arriving in the same cycle.
- Counters:
  - stall_cnt increments on every cycle with pc_we=0 outside reset.
  - flush_cnt increments on each entry to FLUSH.
  - Both wrap modulo 2^CNT_W.
- Reset (resetl=1 at a rising edge), including mid-MEM_WAIT or FLUSH:
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
  - While resetl=1: pc_we=0, ifid_we=0, all three flushes=1, freeze=0, idex_bubble=1.
  - Forward selects and forwarded operands remain combinational throughout.
- MEM_LAT=1: the MEM_WAIT state is unreachable and mw=0.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, MEM_WAIT, FLUSH};
  - forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - ZERO_REG default 31.
- One sub-module, fwd_sel: a combinational forwarding comparator plus 3:1 mux.
  - Parametrised by DATA_W and RADDR_W.
  - Instantiated twice, for operands A and B.

Test Plan:
- mem_rd=3, mem_regwrite=1, wb_rd=3, wb_regwrite=1, ex_rm=3, mem_alu=0x11, wb_data=0x22 -> fwd_a=10, ex_opnd_a=0x11 (MEM wins).
- ex_rm=31, mem_rd=31, mem_regwrite=1 -> fwd_a=00, ex_opnd_a=ex_rdata_a (XZR is never forwarded).
- ex_memread=1, ex_rd=5, id_rn=5, id_rn_used=1 -> exactly one cycle of pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt goes 0->1.
- MEM_LAT=4, mem_req=1, mem_ready held 0 -> freeze=1 for 3 cycles, then RUN; stall_cnt=3. A variant with mem_ready=1 on cycle 2 exits after 2 cycles.
- br_taken=1 together with lu=1 -> FLUSH wins: one cycle with all three flushes=1 and pc_we=1, idex_bubble=0; flush_cnt=1; state returns to RUN.
- resetl=1 asserted during MEM_WAIT with wait_cnt=2 -> next cycle state=RUN, counters=0, flushes=1, pc_we=0 until resetl returns to 0.
